// File: rtl/alu_pipe.sv
// Handshaked N-bit ALU: single-cycle arithmetic/logic ops plus an N-cycle
// restoring divider, all feeding a one-entry output register with flags.
module alu_pipe #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     op_code,
  input  logic [N-1:0]   inp1,
  input  logic [N-1:0]   inp2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] outp,
  output logic           flag_zero,
  output logic           flag_err
);

  localparam int W  = 2 * N;
  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_DIV = 3'b011,
    OP_OR  = 3'b100, OP_AND = 3'b101, OP_XOR = 3'b110, OP_ILL = 3'b111
  } op_e;

  typedef enum logic {IDLE, DIV_RUN} state_e;

  state_e        state, state_next;
  logic [CW-1:0] cnt;
  logic [N-1:0]  div_rem, div_quot, div_den;
  logic [N-1:0]  rem_next, quot_next;
  logic [N:0]    trial, diff;
  logic          accept, start_div, div_done, pop;
  logic [W-1:0]  single_res, a_ext, b_ext;
  logic          single_err;

  assign accept    = in_valid & in_ready;
  assign start_div = accept && (op_code == OP_DIV) && (inp2 != '0);
  assign div_done  = (state == DIV_RUN) && (cnt == '0);
  assign pop       = out_valid & out_ready;
  assign a_ext     = W'(inp1);
  assign b_ext     = W'(inp2);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    single_res = '0;
    single_err = 1'b0;
    case (op_e'(op_code))
      OP_ADD:  single_res = a_ext + b_ext;
      OP_SUB:  single_res = a_ext - b_ext;
      OP_MUL:  single_res = a_ext * b_ext;
      OP_DIV: begin
        // Only reaches the output register when the divisor is zero.
        single_res = {inp1, {N{1'b1}}};
        single_err = 1'b1;
      end
      OP_OR:   single_res = a_ext | b_ext;
      OP_AND:  single_res = a_ext & b_ext;
      OP_XOR:  single_res = a_ext ^ b_ext;
      default: single_err = 1'b1;
    endcase
  end

  // One restoring step: no borrow out of diff means the divisor fits.
  always_comb begin
    trial     = {div_rem, div_quot[N-1]};
    diff      = trial - {1'b0, div_den};
    rem_next  = diff[N] ? trial[N-1:0] : diff[N-1:0];
    quot_next = {div_quot[N-2:0], ~diff[N]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_div) state_next = DIV_RUN;
      DIV_RUN: if (div_done)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) && (!out_valid || out_ready);
  end

  // NOTE: divider working registers are reset too, so an aborted division leaves no residue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      div_rem  <= '0;
      div_quot <= '0;
      div_den  <= '0;
    end else if (start_div) begin
      cnt      <= CW'(N - 1);
      div_rem  <= '0;
      div_quot <= inp1;
      div_den  <= inp2;
    end else if (state == DIV_RUN) begin
      cnt      <= cnt - CW'(1);
      div_rem  <= rem_next;
      div_quot <= quot_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      outp      <= '0;
      flag_zero <= 1'b0;
      flag_err  <= 1'b0;
    end else if (accept && !start_div) begin
      out_valid <= 1'b1;
      outp      <= single_res;
      flag_zero <= (single_res == '0);
      flag_err  <= single_err;
    end else if (div_done) begin
      out_valid <= 1'b1;
      outp      <= {rem_next, quot_next};
      flag_zero <= ({rem_next, quot_next} == '0);
      flag_err  <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed N=4 vectors with literal expectations, plus a
// random N=8 run, both scored against an arithmetic reference model.
module tb_alu_pipe;

  logic clk, reset;

  logic       iv4, ir4, ov4, or4, fz4, fe4;
  logic [2:0] op4;
  logic [3:0] a4, b4;
  logic [7:0] o4;

  logic        iv8, ir8, ov8, or8, fz8, fe8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic [15:0] o8;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [15:0] res;
    logic        err;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;

  alu_pipe #(.N(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .op_code(op4),
    .inp1(a4), .inp2(b4), .out_valid(ov4), .out_ready(or4), .outp(o4),
    .flag_zero(fz4), .flag_err(fe4)
  );

  alu_pipe #(.N(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .op_code(op8),
    .inp1(a8), .inp2(b8), .out_valid(ov8), .out_ready(or8), .outp(o8),
    .flag_zero(fz8), .flag_err(fe8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the operation definitions, for width n.
  function automatic exp_t model(input logic [2:0] op, input int a, input int b, input int n);
    exp_t e;
    int   r;
    int unsigned mask2;
    mask2 = (32'd1 << (2 * n)) - 1;
    e.err = 1'b0;
    r     = 0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a * b;
      3'd3: if (b == 0) begin
              r = (a << n) | ((1 << n) - 1);
              e.err = 1'b1;
            end else begin
              r = ((a % b) << n) | (a / b);
            end
      3'd4: r = a | b;
      3'd5: r = a & b;
      3'd6: r = a ^ b;
      default: begin r = 0; e.err = 1'b1; end
    endcase
    e.res = 16'(int'(r) & int'(mask2));
    return e;
  endfunction

  // Handshakes are evaluated at negedge: inputs and outputs are stable until
  // the next rising edge, so what is seen here is what that edge transfers.
  always @(negedge clk) begin
    if (reset) begin
      q4.delete();
    end else begin
      if (ov4 && or4) begin
        if (q4.size() == 0) check("sb4_unexpected_result", 32'd1, 32'd0);
        else begin
          e4 = q4.pop_front();
          check("sb4_outp", 32'(o4), 32'(e4.res));
          check("sb4_err",  32'(fe4), 32'(e4.err));
          check("sb4_zero", 32'(fz4), 32'(e4.res == 16'd0));
        end
      end
      if (ov4 && !or4) check("sb4_backpressure_in_ready", 32'(ir4), 32'd0);
      if (iv4 && ir4) q4.push_back(model(op4, int'(a4), int'(b4), 4));
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      q8.delete();
    end else begin
      if (ov8 && or8) begin
        if (q8.size() == 0) check("sb8_unexpected_result", 32'd1, 32'd0);
        else begin
          e8 = q8.pop_front();
          check("sb8_outp", 32'(o8), 32'(e8.res));
          check("sb8_err",  32'(fe8), 32'(e8.err));
          check("sb8_zero", 32'(fz8), 32'(e8.res == 16'd0));
        end
      end
      if (ov8 && !or8) check("sb8_backpressure_in_ready", 32'(ir8), 32'd0);
      if (iv8 && ir8) q8.push_back(model(op8, int'(a8), int'(b8), 8));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    iv4 = 1'b1; op4 = op; a4 = a; b4 = b;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    reset = 1'b1;
    iv4 = 0; op4 = 0; a4 = 0; b4 = 0; or4 = 1;
    iv8 = 0; op8 = 0; a8 = 0; b8 = 0; or8 = 1;

    // Model pins.
    m = model(3'd1, 3, 5, 4);  check("model_sub", 32'(m.res), 32'h00FE);
    m = model(3'd3, 13, 4, 4); check("model_div", 32'(m.res), 32'h0013);
    m = model(3'd3, 9, 0, 4);  check("model_div0", 32'({m.err, m.res}), 32'h1009F);

    // Reset values.
    step(); step();
    check("rst_outp", 32'(o4), 32'h0);
    check("rst_out_valid", 32'(ov4), 32'h0);
    check("rst_flags", 32'({fz4, fe4}), 32'h0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(ir4), 32'h1);

    // ADD F+F.
    drive4(3'd0, 4'hF, 4'hF);
    step(); iv4 = 0;
    check("add_valid", 32'(ov4), 32'h1);
    check("add_outp", 32'(o4), 32'h1E);
    check("add_flags", 32'({fz4, fe4}), 32'h0);
    check("add_in_ready", 32'(ir4), 32'h1);
    step();
    check("add_popped", 32'(ov4), 32'h0);

    // Back-to-back SUB, MUL, XOR.
    drive4(3'd1, 4'd3, 4'd5);
    step();
    check("b2b_sub", 32'(o4), 32'hFE);
    drive4(3'd2, 4'hF, 4'hF);
    step();
    check("b2b_mul", 32'(o4), 32'hE1);
    check("b2b_mul_valid", 32'(ov4), 32'h1);
    drive4(3'd6, 4'hA, 4'hA);
    step(); iv4 = 0;
    check("b2b_xor", 32'({fz4, o4}), 32'h100);
    step();
    check("b2b_drained", 32'(ov4), 32'h0);

    // DIV 13/4: busy for N cycles, result exactly N edges after accept.
    drive4(3'd3, 4'd13, 4'd4);
    step(); iv4 = 0;
    for (int i = 0; i < 3; i++) begin
      check("div_busy_in_ready", 32'(ir4), 32'h0);
      check("div_busy_valid", 32'(ov4), 32'h0);
      step();
    end
    check("div_busy_last", 32'({ir4, ov4}), 32'h0);
    step();
    check("div_result", 32'({ov4, fe4, o4}), 32'h213);

    // DIV 9/0: single-cycle error path.
    drive4(3'd3, 4'd9, 4'd0);
    check("div0_in_ready", 32'(ir4), 32'h1);
    step(); iv4 = 0;
    check("div0_result", 32'({ov4, fe4, o4}), 32'h39F);
    step();

    // Backpressure: second op waits until the first result is popped.
    or4 = 1'b0;
    drive4(3'd0, 4'd2, 4'd3);
    step();
    drive4(3'd4, 4'h5, 4'hA);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_outp", 32'({ov4, o4}), 32'h105);
      check("bp_in_ready", 32'(ir4), 32'h0);
      step();
    end
    or4 = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(ir4), 32'h1);
    step(); iv4 = 0;
    check("bp_second_result", 32'({ov4, o4}), 32'h10F);
    step();
    check("bp_drained", 32'(ov4), 32'h0);

    // Asynchronous reset in the middle of DIV 15/1.
    drive4(3'd3, 4'd15, 4'd1);
    step(); iv4 = 0;
    step();
    #2 reset = 1'b1;
    #1;
    check("midrst_outputs", 32'({ov4, fz4, fe4, o4}), 32'h0);
    step();
    reset = 1'b0;
    #1;
    check("midrst_in_ready", 32'(ir4), 32'h1);
    for (int i = 0; i < 6; i++) begin
      check("midrst_no_result", 32'(ov4), 32'h0);
      step();
    end
    drive4(3'd0, 4'd1, 4'd1);
    step(); iv4 = 0;
    check("midrst_add", 32'({ov4, o4}), 32'h102);
    step();

    // Illegal op_code.
    drive4(3'd7, 4'd3, 4'd5);
    step(); iv4 = 0;
    check("illegal", 32'({ov4, fz4, fe4, o4}), 32'h700);
    step();

    // Random N=8 run against the model.
    for (int c = 0; c < 3000; c++) begin
      iv8 = 1'($urandom_range(0, 1));
      or8 = ($urandom_range(0, 3) != 0);
      op8 = 3'($urandom_range(0, 7));
      a8  = 8'($urandom);
      b8  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      step();
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    for (int c = 0; c < 50 && (q8.size() != 0 || ov8); c++) step();
    check("drain8_empty", 32'(q8.size()), 32'd0);
    check("drain4_empty", 32'(q4.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the team's 4-bit registered ALU. Adds operand width N, valid/ready flow control on both sides, an N-cycle iterative divider with remainder, the logical ops (OR, AND, XOR), and status flags. It sits between the stimulus-side operand source and the result consumer, and it is the DUT for the next generation of the UVM ALU environment.

## Interface
- N, 4, operand width in bits (N ≥ 2); result width is 2N.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/op_code presented.
- in_ready  out  1  block can accept; transfer when in_valid & in_ready at a rising edge.
- op_code  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 OR, 101 AND, 110 XOR, 111 illegal.
- inp1, inp2  in  N  unsigned operands.
- out_valid  out  1  result held on outp and flags.
- out_ready  in  1  consumer accepts; pop when out_valid & out_ready at a rising edge.
- outp  out  2N  result.
- flag_zero  out  1  outp == 0 for the held result.
- flag_err  out  1  divide-by-zero or illegal op_code.

## Operation
- Result encodings:
  - ADD: zero-extended sum; the carry lands in bit N.
  - SUB: inp1 − inp2 in 2N-bit two's complement (N=4: 3−5 → 8'hFE).
  - MUL: full 2N-bit unsigned product.
  - OR/AND/XOR: bitwise result, zero-extended to 2N.
  - DIV: outp = {remainder[N-1:0], quotient[N-1:0]}.
  - Illegal (111): outp = 0, flag_err = 1.
  - flag_err = 0 for every other op except divide-by-zero.
- Divide-by-zero (inp2 == 0): outp = {inp1, {N{1'b1}}}, flag_err = 1. Takes the single-cycle path; the divider does not run.
- State machine:
  - IDLE: accepting.
  - DIV_RUN: restoring shift-subtract, one quotient bit per cycle, bit counter N-1 down to 0.
  - Transitions: IDLE → DIV_RUN on an accepted DIV with inp2 ≠ 0. DIV_RUN → IDLE when the counter reaches 0; the result is written to the output register on that edge.
- Output register:
  - Holds one result.
  - Holds outp and flags stable while out_valid & !out_ready.
  - Outputs are don't-care while out_valid = 0 but hold their last values.
- in_ready = (state == IDLE) & (!out_valid | out_ready). Combinational from state, out_valid and out_ready; no combinational path from in_valid.
- Operands and op_code are captured at the accept edge. Input changes after acceptance have no effect.
- Reset (any time, including mid-division): state → IDLE, counter cleared, divider working registers cleared, in-flight operation discarded.

## Timing
- Reset values:
  - outp = 0, out_valid = 0, flag_zero = 0, flag_err = 0.
  - in_ready = 1 once reset deasserts.
  - No transfer occurs while reset = 1.
- Single-cycle ops (including div-by-zero and illegal): accepted at edge k → result and out_valid = 1 after edge k. Latency 1.
- DIV with inp2 ≠ 0: accepted at edge k → in_ready = 0 from after edge k → result and out_valid = 1 after edge k+N. in_ready stays low through the result-write edge k+N.
- Back-to-back: with out_ready held 1, single-cycle ops sustain 1 result per cycle. Pop and push on the same edge are legal; the new result replaces the popped one.
- Backpressure: out_valid & !out_ready forces in_ready = 0, so no result is overwritten or dropped.
- DIV completion while an older result is unpopped cannot occur, because acceptance required an empty or popping output register.
- out_valid clears on a pop edge with no simultaneous accept.

## Test plan
- Reset then ADD, N=4, 4'hF + 4'hF, out_ready = 1 → after 1 cycle outp = 8'h1E, flag_zero = 0, flag_err = 0; in_ready stays 1.
- SUB 3−5, then MUL 15×15, then XOR 4'hA^4'hA, back-to-back, out_ready = 1 → consecutive results 8'hFE, 8'hE1, 8'h00 (flag_zero = 1); one result per cycle.
- DIV 13/4, N=4 → in_ready low for 4 cycles; outp = 8'h13 (rem 1, quot 3) exactly 4 cycles after accept. Then DIV 9/0 → 1-cycle result 8'h9F, flag_err = 1.
- Backpressure: out_ready = 0 for 5 cycles after an ADD while in_valid stays high with a second op → outp stable, in_ready = 0; raising out_ready pops the first result and accepts the second on the same edge.
- Reset asserted asynchronously at cycle 2 of a DIV 15/1 → outputs 0 immediately and no result emitted. After deassert, a fresh ADD 1+1 yields 8'h02.
- op_code 111 → outp = 0, flag_err = 1, flag_zero = 1, latency 1. Randomised N=8 run vs. reference model, all ops, random in_valid/out_ready.
